// File: rtl/cpu_seq.sv
// cpu_seq -- multi-cycle FETCH/DECODE/EXECUTE/WRITE_BACK instruction sequencer
// with the program counter.
//
// Sits between the instruction memory and the decode/alu/regbank datapath.
// Fetches use a req/ack handshake, so fetch latency can vary. EXECUTE stalls
// while exec_busy is high. A HALT instruction can be resumed, single-step debug
// is supported, and branches may be absolute or pc-relative.
//
// Handshake: imem_req is high in every FETCH cycle and holds until the cycle
// in which imem_ack is high. In that cycle imem_data is captured into inst.
// imem_ack in any other state is ignored.
//
// Optional feature: define CPU_SEQ_PERF_EN to build the cycle_count and
// retired_count performance counters. When it is undefined, both ports read 0
// and no counter flops are built. The port list is the same in both builds.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-low reset
//   imem_req       fetch request; the fetch address is pc
//   imem_ack       fetch complete; imem_data is valid this cycle
//   imem_data      instruction word
//   is_halt        decoded HALT, sampled in DECODE
//   exec_busy      multi-cycle execute in progress, sampled in EXECUTE
//   no_writeback   suppress the register write, sampled in WRITE_BACK
//   take_branch    branch taken, sampled in WRITE_BACK
//   is_relative    1 = pc-relative target, 0 = absolute target
//   branch_addr    branch target or two's-complement offset
//   single_step    level; halt after every retired instruction
//   resume         pulse; leave HALTED
//   pc             current program counter
//   inst           latched instruction
//   state          FETCH=0 DECODE=1 EXECUTE=2 WRITE_BACK=3 HALTED=4
//   decode_en/exec_en/wb_en  stage strobes
//   halted         state == HALTED
//   cycle_count/retired_count  performance counters
module cpu_seq #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] PC_RESET     = '0,
   parameter logic [WIDTH-1:0] PC_STEP      = WIDTH'(1),
   parameter bit               START_HALTED = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_data,
   input  logic             is_halt,
   input  logic             exec_busy,
   input  logic             no_writeback,
   input  logic             take_branch,
   input  logic             is_relative,
   input  logic [WIDTH-1:0] branch_addr,
   input  logic             single_step,
   input  logic             resume,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] inst,
   output logic [2:0]       state,
   output logic             decode_en,
   output logic             exec_en,
   output logic             wb_en,
   output logic             halted,
   output logic [WIDTH-1:0] cycle_count,
   output logic [WIDTH-1:0] retired_count
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_WB     = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;
   localparam logic [2:0] S_RESET  = START_HALTED ? S_HALTED : S_FETCH;

   // Records why we are halted. After a HALT instruction, pc still points at
   // the HALT, so resume must step past it. After a single step, pc already
   // points at the next instruction.
   localparam logic CAUSE_INSN = 1'b0;
   localparam logic CAUSE_STEP = 1'b1;

   logic [2:0]       state_q;
   logic [2:0]       state_d;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] inst_q;
   logic             cause_q;
   logic [WIDTH-1:0] pc_wb;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_RESET;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (imem_ack) state_d = S_DECODE;
         S_DECODE: state_d = is_halt ? S_HALTED : S_EXEC;
         S_EXEC:   if (!exec_busy) state_d = S_WB;
         S_WB:     state_d = single_step ? S_HALTED : S_FETCH;
         S_HALTED: if (resume) state_d = S_FETCH;
         default:  state_d = S_FETCH;  // encodings 5..7 recover
      endcase
   end

   // Output logic. imem_req is gated by reset so that a request is abandoned
   // as soon as reset is asserted.
   always_comb begin
      imem_req  = reset && (state_q == S_FETCH);
      decode_en = (state_q == S_DECODE);
      exec_en   = (state_q == S_EXEC);
      wb_en     = (state_q == S_WB) && !no_writeback;
      halted    = (state_q == S_HALTED);
   end

   // Next pc at WRITE_BACK. All arithmetic wraps modulo 2^WIDTH.
   always_comb begin
      pc_wb = pc_q + PC_STEP;
      if (take_branch) pc_wb = is_relative ? (pc_q + branch_addr) : branch_addr;
   end

   // Datapath registers: pc, latched instruction, halt cause
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= PC_RESET;
         inst_q  <= '0;
         cause_q <= CAUSE_INSN;
      end else begin
         case (state_q)
            S_FETCH:  if (imem_ack) inst_q <= imem_data;
            S_DECODE: if (is_halt) cause_q <= CAUSE_INSN;
            S_WB: begin
               pc_q <= pc_wb;
               if (single_step) cause_q <= CAUSE_STEP;
            end
            S_HALTED: if (resume && cause_q == CAUSE_INSN) pc_q <= pc_q + PC_STEP;
            default: ;
         endcase
      end
   end

   assign pc    = pc_q;
   assign inst  = inst_q;
   assign state = state_q;

`ifdef CPU_SEQ_PERF_EN
   logic [WIDTH-1:0] cyc_q;
   logic [WIDTH-1:0] ret_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (state_q != S_HALTED) cyc_q <= cyc_q + WIDTH'(1);
         if (state_q == S_WB)     ret_q <= ret_q + WIDTH'(1);
      end
   end

   assign cycle_count   = cyc_q;
   assign retired_count = ret_q;
`else
   assign cycle_count   = '0;
   assign retired_count = '0;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq (default parameters). An instruction-level
// reference model tracks the expected pc, latched instruction, halt cause and
// counters. Random junk is driven on every input that is not sampled in the
// current state, so the bench also checks that those inputs are ignored.
module tb_cpu_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         imem_req, imem_ack, is_halt, exec_busy, no_writeback;
   logic         take_branch, is_relative, single_step, resume;
   logic [W-1:0] imem_data, branch_addr, pc, inst, cycle_count, retired_count;
   logic [2:0]   state;
   logic         decode_en, exec_en, wb_en, halted;

   cpu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
      .imem_data(imem_data), .is_halt(is_halt), .exec_busy(exec_busy),
      .no_writeback(no_writeback), .take_branch(take_branch),
      .is_relative(is_relative), .branch_addr(branch_addr),
      .single_step(single_step), .resume(resume), .pc(pc), .inst(inst),
      .state(state), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
      .halted(halted), .cycle_count(cycle_count), .retired_count(retired_count)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // Scoreboard state and reference model
   int           tests = 0;
   int           fails = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_pc, m_inst, m_cyc, m_ret;
   bit           m_cause_step;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_counters();
`ifdef CPU_SEQ_PERF_EN
      chk("cycle_count", cycle_count, m_cyc);
      chk("retired_count", retired_count, m_ret);
`else
      chk("cycle_count_off", cycle_count, 0);
      chk("retired_count_off", retired_count, 0);
`endif
   endtask

   task automatic model_reset();
      m_pc = '0; m_inst = '0; m_cyc = '0; m_ret = '0; m_cause_step = 0;
      exp_q.delete();
   endtask

   // Drive random values on every input; the state tasks then override the
   // inputs that matter in the current cycle.
   task automatic junk();
      imem_ack     = 1'($urandom_range(0, 1));
      imem_data    = $urandom();
      is_halt      = 1'($urandom_range(0, 1));
      exec_busy    = 1'($urandom_range(0, 1));
      no_writeback = 1'($urandom_range(0, 1));
      take_branch  = 1'($urandom_range(0, 1));
      is_relative  = 1'($urandom_range(0, 1));
      branch_addr  = $urandom();
      single_step  = 1'($urandom_range(0, 1));
      resume       = 1'($urandom_range(0, 1));
   endtask

   // Cross one rising edge and return to the falling edge. A counted edge
   // is one where the DUT is not halted.
   task automatic tick(input bit counted);
      @(posedge clk);
      if (counted) m_cyc++;
      @(negedge clk);
   endtask

   task automatic chk_halted(input string tag);
      junk(); resume = 1'b0; #1;
      chk({tag, "_state"}, state, 4);
      chk({tag, "_halted"}, halted, 1);
      chk({tag, "_strobes"}, {decode_en, exec_en, wb_en, imem_req}, 0);
      chk({tag, "_pc"}, pc, m_pc);
      chk_counters();
   endtask

   // One instruction, starting at a falling edge with the DUT in FETCH.
   task automatic run_instr(input int delay, input logic [W-1:0] data, input bit halt,
                            input int stall, input bit nowb, input bit br, input bit rel,
                            input logic [W-1:0] addr, input bit step);
      for (int k = 0; k <= delay; k++) begin
         junk();
         imem_ack = (k == delay);
         if (k == delay) begin
            imem_data = data;
            exp_q.push_back(data);
         end
         #1;
         chk("fetch_state", state, 0);
         chk("fetch_req", imem_req, 1);
         chk("fetch_pc", pc, m_pc);
         chk("fetch_inst_hold", inst, m_inst);
         tick(1);
      end
      m_inst = exp_q.pop_front();
      junk(); is_halt = halt; #1;
      chk("decode_state", state, 1);
      chk("decode_strobes", {decode_en, exec_en, wb_en, imem_req}, 4'b1000);
      chk("decode_inst", inst, m_inst);
      tick(1);
      if (halt) begin
         m_cause_step = 0;
         chk_halted("halt");
         return;
      end
      for (int s = 0; s <= stall; s++) begin
         junk(); exec_busy = (s < stall); #1;
         chk("exec_state", state, 2);
         chk("exec_strobes", {decode_en, exec_en, wb_en, imem_req}, 4'b0100);
         chk("exec_inst", inst, m_inst);
         tick(1);
      end
      junk();
      no_writeback = nowb; take_branch = br; is_relative = rel;
      branch_addr = addr; single_step = step;
      #1;
      chk("wb_state", state, 3);
      chk("wb_en", wb_en, !nowb);
      chk("wb_pc", pc, m_pc);
      tick(1);
      m_ret++;
      m_pc = br ? (rel ? m_pc + addr : addr) : m_pc + 1;
      if (step) m_cause_step = 1;
      junk(); resume = 1'b0; #1;
      chk("post_wb_state", state, step ? 3'd4 : 3'd0);
      chk("post_wb_pc", pc, m_pc);
      chk("post_wb_inst", inst, m_inst);
      chk_counters();
   endtask

   task automatic do_resume();
      junk(); resume = 1'b1; #1;
      chk("resume_halted", halted, 1);
      tick(0);
      if (!m_cause_step) m_pc = m_pc + 1;
      junk(); #1;
      chk("resume_state", state, 0);
      chk("resume_pc", pc, m_pc);
   endtask

   task automatic idle_halted(input int n);
      for (int i = 0; i < n; i++) begin
         chk_halted("idle");
         tick(0);
      end
   endtask

   initial begin
      // Reset: an ack arriving during reset must be ignored
      junk(); imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
      #1;
      chk("rst_state", state, 0);
      chk("rst_pc", pc, 0);
      chk("rst_inst", inst, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_halted", halted, 0);
      @(negedge clk); @(negedge clk);
      chk("rst_ack_ignored", inst, 0);
      model_reset();
      chk_counters();
      reset = 1'b1;

      // Sequential flow, ack in the same cycle as the request
      for (int i = 0; i < 3; i++) run_instr(0, $urandom(), 0, 0, 0, 0, 0, 0, 0);
      chk("seq_pc3", pc, 3);
      // Fetch wait of 3 cycles
      run_instr(3, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
      // Branches
      run_instr(0, $urandom(), 0, 0, 0, 1, 0, 32'd10, 0);
      run_instr(0, $urandom(), 0, 0, 0, 1, 1, 32'hFFFF_FFFE, 0);
      chk("rel_branch_pc", pc, 8);
      run_instr(1, $urandom(), 0, 0, 0, 1, 0, 32'h40, 0);
      chk("abs_branch_pc", pc, 32'h40);
      run_instr(0, $urandom(), 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
      run_instr(0, $urandom(), 0, 0, 0, 0, 0, 0, 0);
      chk("wrap_pc", pc, 0);
      // Stall of 5 cycles and writeback suppression
      run_instr(0, $urandom(), 0, 5, 1, 0, 0, 0, 0);
      // HALT at pc 7, then resume
      run_instr(0, $urandom(), 0, 0, 0, 1, 0, 32'd7, 0);
      run_instr(0, 32'hFFFF_0000, 1, 0, 0, 0, 0, 0, 0);
      chk("halt_pc", pc, 7);
      tick(0);
      idle_halted(2);
      do_resume();
      chk("halt_resume_pc", pc, 8);
      // Single step: resume does not add the pc step
      run_instr(0, $urandom(), 0, 1, 0, 0, 0, 0, 1);
      idle_halted(1);
      do_resume();
      chk("step_resume_pc", pc, 9);
      run_instr(0, $urandom(), 0, 0, 0, 1, 1, 32'd16, 1);
      do_resume();
      chk("step_branch_pc", pc, 25);
      run_instr(0, $urandom(), 0, 0, 0, 0, 0, 0, 0);

      // Randomised instruction stream
      for (int i = 0; i < 40; i++) begin
         bit h, st;
         h  = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 3) == 0);
         run_instr($urandom_range(0, 3), $urandom(), h, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom(), st);
         if (h || st) begin
            if (h) tick(0);
            idle_halted($urandom_range(0, 2));
            do_resume();
         end
      end

      // Reset in the middle of EXECUTE takes effect immediately
      junk(); imem_ack = 1'b1; imem_data = 32'h0000_ABCD; #1;
      chk("mid_fetch_state", state, 0);
      tick(1);
      junk(); is_halt = 1'b0; tick(1);
      junk(); exec_busy = 1'b1; #1;
      chk("mid_exec_state", state, 2);
      @(posedge clk); #2;
      reset = 1'b0; #1;
      chk("async_rst_state", state, 0);
      chk("async_rst_pc", pc, 0);
      chk("async_rst_inst", inst, 0);
      chk("async_rst_req", imem_req, 0);
      model_reset();
      chk_counters();
      @(negedge clk);
      junk(); imem_ack = 1'b1; imem_data = 32'h5555_AAAA;
      @(negedge clk);
      chk("rst_ack_ignored2", inst, 0);
      reset = 1'b1;
      run_instr(0, $urandom(), 0, 0, 0, 0, 0, 0, 0);
      run_instr(0, $urandom(), 0, 0, 0, 0, 0, 0, 0);
      chk("two_instr_pc", pc, 2);
`ifdef CPU_SEQ_PERF_EN
      chk("perf_retired_2", retired_count, 2);
      chk("perf_cycles_8", cycle_count, 8);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
